// File: rtl/uart_rx.sv
// uart_rx: oversampling UART receiver front end.
// Synchronises the asynchronous Rx line, frames start/data/parity/stop bits
// on Baud_Tick enables, and hands each good character straight to the
// receive FIFO through Rx_Data/Data_Rdy. Errored characters only raise
// Parity_Err / Frame_Err strobes and never touch Rx_Data.
module uart_rx #(
  parameter int DATA_BITS  = 8,   // 5..9, LSB first on the line
  parameter int OVERSAMPLE = 16,  // ticks per bit, even, >= 4
  parameter int PARITY_EN  = 1,   // 1: a parity bit follows the data bits
  parameter int PARITY_ODD = 0    // 1: odd parity, 0: even parity
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 Rx_In,
  input  logic                 Baud_Tick,
  output logic [DATA_BITS-1:0] Rx_Data,
  output logic                 Data_Rdy,
  output logic                 Parity_Err,
  output logic                 Frame_Err,
  output logic                 Rx_Busy
);

  localparam int SW = $clog2(OVERSAMPLE);
  localparam int IW = $clog2(DATA_BITS + 1);

  localparam logic [SW-1:0] SC_ZERO  = SW'(0);
  localparam logic [SW-1:0] SC_ONE   = SW'(1);
  localparam logic [SW-1:0] SC_HALF  = SW'(OVERSAMPLE / 2 - 1);
  localparam logic [SW-1:0] SC_LAST  = SW'(OVERSAMPLE - 1);
  localparam logic [IW-1:0] IDX_ZERO = IW'(0);
  localparam logic [IW-1:0] IDX_ONE  = IW'(1);
  localparam logic [IW-1:0] IDX_LAST = IW'(DATA_BITS - 1);
  localparam logic          PAR_EN   = (PARITY_EN != 0) ? 1'b1 : 1'b0;
  localparam logic          PAR_ODD  = (PARITY_ODD != 0) ? 1'b1 : 1'b0;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP   = 3'd4,
    ST_BREAK  = 3'd5
  } state_t;

  // Parity check: 1 means the received parity bit disagrees with the data.
  function automatic logic parity_mismatch(
    input logic [DATA_BITS-1:0] data,
    input logic                 bit_in,
    input logic                 odd
  );
    return (^data) ^ bit_in ^ odd;
  endfunction

  // Synchroniser flops; rx_r is the only view of the line the FSM uses.
  logic rx_meta_r;
  logic rx_r;

  // FSM state and datapath registers, with their next-state values.
  state_t                 state_r;
  state_t                 state_s;
  logic [SW-1:0]          sc_r;
  logic [SW-1:0]          sc_s;
  logic [IW-1:0]          idx_r;
  logic [IW-1:0]          idx_s;
  logic [DATA_BITS-1:0]   shift_r;
  logic [DATA_BITS-1:0]   shift_s;
  logic                   perr_r;
  logic                   perr_s;

  // Next values of the registered outputs.
  logic [DATA_BITS-1:0]   data_s;
  logic                   rdy_s;
  logic                   perr_strobe_s;
  logic                   ferr_s;
  logic                   busy_s;

  // Stop-bit decision point: the one clock where a character is judged.
  logic                   stop_sample_s;

  // Two-flop synchroniser for the asynchronous line; idles high.
  always_ff @(posedge clk) begin
    if (rst) begin
      rx_meta_r <= 1'b1;
      rx_r      <= 1'b1;
    end else begin
      rx_meta_r <= Rx_In;
      rx_r      <= rx_meta_r;
    end
  end

  // State register plus the counters and shift register that move with it.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= ST_IDLE;
      sc_r    <= SC_ZERO;
      idx_r   <= IDX_ZERO;
      shift_r <= '0;
      perr_r  <= 1'b0;
    end else begin
      state_r <= state_s;
      sc_r    <= sc_s;
      idx_r   <= idx_s;
      shift_r <= shift_s;
      perr_r  <= perr_s;
    end
  end

  // Next-state logic: everything advances only on Baud_Tick.
  always_comb begin
    state_s = state_r;
    sc_s    = sc_r;
    idx_s   = idx_r;
    shift_s = shift_r;
    perr_s  = perr_r;
    if (Baud_Tick) begin
      case (state_r)
        ST_IDLE: begin
          sc_s = SC_ZERO;
          if (!rx_r) begin
            state_s = ST_START;
          end else begin
            state_s = ST_IDLE;
          end
        end
        ST_START: begin
          if (sc_r == SC_HALF) begin
            sc_s = SC_ZERO;
            if (!rx_r) begin
              // Start bit confirmed at its centre; from here on sample
              // once per full bit period.
              state_s = ST_DATA;
              idx_s   = IDX_ZERO;
              perr_s  = 1'b0;
            end else begin
              // Low pulse shorter than half a bit: treat as a glitch.
              state_s = ST_IDLE;
            end
          end else begin
            sc_s = sc_r + SC_ONE;
          end
        end
        ST_DATA: begin
          if (sc_r == SC_LAST) begin
            sc_s    = SC_ZERO;
            shift_s = {rx_r, shift_r[DATA_BITS-1:1]};
            if (idx_r == IDX_LAST) begin
              idx_s   = IDX_ZERO;
              state_s = PAR_EN ? ST_PARITY : ST_STOP;
            end else begin
              idx_s = idx_r + IDX_ONE;
            end
          end else begin
            sc_s = sc_r + SC_ONE;
          end
        end
        ST_PARITY: begin
          if (sc_r == SC_LAST) begin
            sc_s    = SC_ZERO;
            perr_s  = parity_mismatch(shift_r, rx_r, PAR_ODD);
            state_s = ST_STOP;
          end else begin
            sc_s = sc_r + SC_ONE;
          end
        end
        ST_STOP: begin
          if (sc_r == SC_LAST) begin
            sc_s   = SC_ZERO;
            perr_s = 1'b0;
            if (rx_r) begin
              state_s = ST_IDLE;
            end else begin
              // Line still low at the stop centre: wait for it to return
              // high so a held-low line cannot look like a new start.
              state_s = ST_BREAK;
            end
          end else begin
            sc_s = sc_r + SC_ONE;
          end
        end
        ST_BREAK: begin
          sc_s = SC_ZERO;
          if (rx_r) begin
            state_s = ST_IDLE;
          end else begin
            state_s = ST_BREAK;
          end
        end
        default: begin
          state_s = ST_IDLE;
          sc_s    = SC_ZERO;
          idx_s   = IDX_ZERO;
          perr_s  = 1'b0;
        end
      endcase
    end else begin
      state_s = state_r;
    end
  end

  // Output logic: strobes are produced only at the stop-bit centre tick.
  always_comb begin
    data_s        = Rx_Data;
    rdy_s         = 1'b0;
    perr_strobe_s = 1'b0;
    ferr_s        = 1'b0;
    busy_s        = (state_s != ST_IDLE);
    stop_sample_s = Baud_Tick && (state_r == ST_STOP) && (sc_r == SC_LAST);
    if (stop_sample_s) begin
      if (rx_r) begin
        if (!perr_r) begin
          data_s = shift_r;
          rdy_s  = 1'b1;
        end else begin
          perr_strobe_s = 1'b1;
        end
      end else begin
        ferr_s        = 1'b1;
        perr_strobe_s = perr_r;
      end
    end else begin
      rdy_s = 1'b0;
    end
  end

  // Registered outputs; reset clears every strobe in the same clock.
  always_ff @(posedge clk) begin
    if (rst) begin
      Rx_Data    <= '0;
      Data_Rdy   <= 1'b0;
      Parity_Err <= 1'b0;
      Frame_Err  <= 1'b0;
      Rx_Busy    <= 1'b0;
    end else begin
      Rx_Data    <= data_s;
      Data_Rdy   <= rdy_s;
      Parity_Err <= perr_strobe_s;
      Frame_Err  <= ferr_s;
      Rx_Busy    <= busy_s;
    end
  end

endmodule
